// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment by control-token hunting plus
// 10b -> 8b / control decode for one HDMI data channel.
// Optional build macro TMDS_TERC4_EN adds TERC4 nibble detection
// (terc4 / terc4_vld ports); without it those ports and the matcher are absent.
//
// Handshake: vld is a qualifier only (no ready). When vld=1, de selects
// which of dout (de=1) or ctrl (de=0) carries the decoded word; the sink
// must accept every vld cycle.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT    = 16,
  parameter int SLIP_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 8,
  parameter int LOSS_TIMEOUT  = 8192
) (
  input  logic       clk,
  input  logic       ext_reset,
  input  logic [9:0] din,
  output logic       bitslip,
  output logic       locked,
  output logic       vld,
  output logic [7:0] dout,
  output logic [1:0] ctrl,
  output logic       de
`ifdef TMDS_TERC4_EN
  ,
  output logic [3:0] terc4,
  output logic       terc4_vld
`endif
);

  localparam int MISS_MAX = (SLIP_TIMEOUT > LOSS_TIMEOUT) ? SLIP_TIMEOUT : LOSS_TIMEOUT;
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [RW-1:0] RUN_LIM    = RW'(LOCK_COUNT);
  localparam logic [MW-1:0] SLIP_LIM   = MW'(SLIP_TIMEOUT);
  localparam logic [MW-1:0] LOSS_LIM   = MW'(LOSS_TIMEOUT);
  localparam logic [MW-1:0] MISS_SAT   = MW'(MISS_MAX);
  localparam logic [SW-1:0] SETTLE_LIM = SW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [9:0]    din_q;
  logic [RW-1:0] run_cnt, run_nx, run_inc;
  logic [MW-1:0] miss_cnt, miss_nx, miss_inc;
  logic [SW-1:0] settle_cnt, settle_nx;
  logic          is_ctrl;
  logic [1:0]    ctrl_val;
  logic [7:0]    d_word;
  logic [7:0]    q_word;
  logic          emit;

  // Input register: every decision below works on the registered word.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) din_q <= '0;
    else            din_q <= din;
  end

  // Control-token recognition on the registered word.
  always_comb begin
    is_ctrl  = 1'b1;
    ctrl_val = 2'b00;
    case (din_q)
      10'h354: ctrl_val = 2'b00;
      10'h0AB: ctrl_val = 2'b01;
      10'h154: ctrl_val = 2'b10;
      10'h2AB: ctrl_val = 2'b11;
      default: is_ctrl  = 1'b0;
    endcase
  end

  // Video data decode: undo the optional inversion, then the XOR/XNOR chain.
  always_comb begin
    d_word    = din_q[9] ? ~din_q[7:0] : din_q[7:0];
    q_word    = '0;
    q_word[0] = d_word[0];
    for (int i = 1; i < 8; i++) begin
      q_word[i] = din_q[8] ? (d_word[i] ^ d_word[i-1]) : ~(d_word[i] ^ d_word[i-1]);
    end
  end

  // Saturating increments; the counters never wrap.
  assign run_inc  = (run_cnt  == RUN_LIM)  ? run_cnt  : run_cnt  + RW'(1);
  assign miss_inc = (miss_cnt == MISS_SAT) ? miss_cnt : miss_cnt + MW'(1);

  // FSM and counter registers.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      state      <= SEARCH;
      run_cnt    <= '0;
      miss_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_nx;
      run_cnt    <= run_nx;
      miss_cnt   <= miss_nx;
      settle_cnt <= settle_nx;
    end
  end

  // Next-state logic: hunt for a token run, slip on timeout, drop lock on loss.
  always_comb begin
    state_nx  = state;
    run_nx    = run_cnt;
    miss_nx   = miss_cnt;
    settle_nx = settle_cnt;
    case (state)
      SEARCH: begin
        if (is_ctrl) begin
          run_nx  = run_inc;
          miss_nx = '0;
          if (run_inc == RUN_LIM) state_nx = LOCKED;
        end else begin
          run_nx  = '0;
          miss_nx = miss_inc;
          if (miss_inc == SLIP_LIM) state_nx = SLIP;
        end
      end
      SLIP: begin
        state_nx  = SETTLE;
        run_nx    = '0;
        miss_nx   = '0;
        settle_nx = '0;
      end
      SETTLE: begin
        run_nx    = '0;
        miss_nx   = '0;
        settle_nx = settle_cnt + SW'(1);
        if (settle_nx == SETTLE_LIM) begin
          state_nx  = SEARCH;
          settle_nx = '0;
        end
      end
      LOCKED: begin
        if (is_ctrl) begin
          miss_nx = '0;
        end else begin
          miss_nx = miss_inc;
          if (miss_inc == LOSS_LIM) begin
            state_nx = SEARCH;
            miss_nx  = '0;
            run_nx   = '0;
          end
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  // A word is emitted only if lock holds across this edge, so the word that
  // causes an unlock is discarded and vld falls together with locked.
  assign emit = (state == LOCKED) && (state_nx == LOCKED);

  // Registered outputs.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      bitslip <= 1'b0;
      locked  <= 1'b0;
      vld     <= 1'b0;
      de      <= 1'b0;
      dout    <= '0;
      ctrl    <= '0;
    end else begin
      bitslip <= (state_nx == SLIP);
      locked  <= (state_nx == LOCKED);
      vld     <= emit;
      if (emit) begin
        if (is_ctrl) begin
          de   <= 1'b0;
          ctrl <= ctrl_val;
          dout <= '0;
        end else begin
          de   <= 1'b1;
          dout <= q_word;
        end
      end else begin
        de   <= 1'b0;
        dout <= '0;
        ctrl <= '0;
      end
    end
  end

`ifdef TMDS_TERC4_EN
  logic       t4_hit;
  logic [3:0] t4_val;

  // TERC4 code match on the registered word.
  always_comb begin
    t4_hit = 1'b1;
    t4_val = 4'h0;
    case (din_q)
      10'b1010011100: t4_val = 4'h0;
      10'b1001100011: t4_val = 4'h1;
      10'b1011100100: t4_val = 4'h2;
      10'b1011100010: t4_val = 4'h3;
      10'b0101110001: t4_val = 4'h4;
      10'b0100011110: t4_val = 4'h5;
      10'b0110001110: t4_val = 4'h6;
      10'b0100111100: t4_val = 4'h7;
      10'b1011001100: t4_val = 4'h8;
      10'b0100111001: t4_val = 4'h9;
      10'b0110011100: t4_val = 4'hA;
      10'b1011000110: t4_val = 4'hB;
      10'b1010001110: t4_val = 4'hC;
      10'b1001110001: t4_val = 4'hD;
      10'b0101100011: t4_val = 4'hE;
      10'b1011000011: t4_val = 4'hF;
      default:        t4_hit = 1'b0;
    endcase
  end

  // TERC4 outputs share the decode timing and the lock qualification.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      terc4     <= '0;
      terc4_vld <= 1'b0;
    end else begin
      terc4_vld <= emit && t4_hit;
      terc4     <= (emit && t4_hit) ? t4_val : 4'h0;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Testbench for tmds_channel_decoder: table-driven decode vectors, hand
// sequences for lock / slip / loss / reset, and randomized bursts checked
// against a stream-level reference model. Define TMDS_TERC4_EN for both
// RTL and bench to cover the TERC4 outputs.
module tb_tmds_channel_decoder;

  localparam int LOCK_N   = 16;
  localparam int SLIP_N   = 32;
  localparam int SETTLE_N = 8;
  localparam int LOSS_N   = 64;
  localparam int W        = 21;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       ext_reset = 1'b0;
  logic [9:0] din = '0;
  logic       bitslip, locked, vld, de;
  logic [7:0] dout;
  logic [1:0] ctrl;
`ifdef TMDS_TERC4_EN
  logic [3:0] terc4;
  logic       terc4_vld;
`endif

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .LOCK_COUNT(LOCK_N), .SLIP_TIMEOUT(SLIP_N),
    .SETTLE_CYCLES(SETTLE_N), .LOSS_TIMEOUT(LOSS_N)
  ) dut (
    .clk(clk), .ext_reset(ext_reset), .din(din),
    .bitslip(bitslip), .locked(locked), .vld(vld),
    .dout(dout), .ctrl(ctrl), .de(de)
`ifdef TMDS_TERC4_EN
    , .terc4(terc4), .terc4_vld(terc4_vld)
`endif
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc;
  int lock_cyc;
  int slip_q[$];
  bit misalign = 1'b0;
  int off = 0;

  // ---------------- reference model ----------------
  logic [7:0]   dec_tab [1024];
  logic [9:0]   terc_tab [16];
  logic [W-1:0] exp_q[$];
  bit           m_locked;
  int           m_run, m_miss, m_blind;
  logic [9:0]   m_wq;
  logic [1:0]   m_ctrl;

  typedef struct {
    logic [9:0] din;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] dout;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decode table built by running the TMDS encoder forward for every byte
  // and every (invert, xor/xnor) choice.
  function automatic void build_tables();
    logic [7:0] bb, qm;
    logic [1:0] vv;
    logic [9:0] w;
    for (int b = 0; b < 256; b++) begin
      for (int v = 0; v < 4; v++) begin
        bb = 8'(b);
        vv = 2'(v);
        qm = '0;
        qm[0] = bb[0];
        for (int i = 1; i < 8; i++) qm[i] = vv[0] ? (qm[i-1] ^ bb[i]) : ~(qm[i-1] ^ bb[i]);
        w = {vv[1], vv[0], (vv[1] ? ~qm : qm)};
        dec_tab[w] = bb;
      end
    end
    terc_tab[0]  = 10'b1010011100; terc_tab[1]  = 10'b1001100011;
    terc_tab[2]  = 10'b1011100100; terc_tab[3]  = 10'b1011100010;
    terc_tab[4]  = 10'b0101110001; terc_tab[5]  = 10'b0100011110;
    terc_tab[6]  = 10'b0110001110; terc_tab[7]  = 10'b0100111100;
    terc_tab[8]  = 10'b1011001100; terc_tab[9]  = 10'b0100111001;
    terc_tab[10] = 10'b0110011100; terc_tab[11] = 10'b1011000110;
    terc_tab[12] = 10'b1010001110; terc_tab[13] = 10'b1001110001;
    terc_tab[14] = 10'b0101100011; terc_tab[15] = 10'b1011000011;
  endfunction

  function automatic int tok_code(input logic [9:0] w);
    case (w)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] w, input int o);
    logic [19:0] x;
    x = {w, w};
    return x[o +: 10];
  endfunction

  function automatic void model_reset();
    m_locked = 1'b0;
    m_run = 0; m_miss = 0; m_blind = 0;
    m_wq = '0; m_ctrl = '0;
    exp_q.delete();
  endfunction

  // One clock edge of the stream-level model: m_wq is the word the
  // decoder judges at this edge, w is the word being captured.
  function automatic void model_edge(input logic [9:0] w);
    int         t;
    bit         was_locked;
    logic       e_slip, e_vld, e_de, e_t4v;
    logic [7:0] e_dout;
    logic [3:0] e_t4;
    was_locked = m_locked;
    t = tok_code(m_wq);
    e_slip = 1'b0;
    if (m_locked) begin
      if (t >= 0) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss == LOSS_N) begin m_locked = 1'b0; m_miss = 0; m_run = 0; end
      end
    end else if (m_blind > 0) begin
      m_blind--; m_run = 0; m_miss = 0;
    end else if (t >= 0) begin
      m_run++; m_miss = 0;
      if (m_run == LOCK_N) m_locked = 1'b1;
    end else begin
      m_run = 0; m_miss++;
      if (m_miss == SLIP_N) begin m_blind = 1 + SETTLE_N; m_miss = 0; e_slip = 1'b1; end
    end
    e_vld = 1'b0; e_de = 1'b0; e_dout = '0; e_t4 = '0; e_t4v = 1'b0;
    if (was_locked && m_locked) begin
      e_vld = 1'b1;
      if (t >= 0) m_ctrl = 2'(t);
      else begin e_de = 1'b1; e_dout = dec_tab[m_wq]; end
`ifdef TMDS_TERC4_EN
      for (int k = 0; k < 16; k++) if (terc_tab[k] == m_wq) begin e_t4v = 1'b1; e_t4 = 4'(k); end
`endif
    end else begin
      m_ctrl = '0;
    end
    exp_q.push_back({e_slip, m_locked, e_vld, e_de, m_ctrl, e_dout, e_t4v, e_t4});
    m_wq = w;
  endfunction

  function automatic logic [W-1:0] act_vec();
`ifdef TMDS_TERC4_EN
    return {bitslip, locked, vld, de, ctrl, dout, terc4_vld, terc4};
`else
    return {bitslip, locked, vld, de, ctrl, dout, 5'b0};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one word (rotated when the misaligned deserializer is modelled),
  // clock it, then compare outputs at the falling edge.
  task automatic step(input logic [9:0] w);
    logic [9:0]   wd;
    logic [W-1:0] e;
    wd  = misalign ? rot(w, off) : w;
    din = wd;
    cyc++;
    @(posedge clk);
    model_edge(wd);
    @(negedge clk);
    e = exp_q.pop_front();
    check("model", 32'(act_vec()), 32'(e));
    if (bitslip === 1'b1) begin
      slip_q.push_back(cyc);
      if (misalign) off = (off + 9) % 10;
    end
    if (locked === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
  endtask

  // Called at a falling edge; reset takes effect asynchronously.
  task automatic do_reset();
    ext_reset = 1'b0;
    #1;
    check("reset_out", 32'(act_vec()), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", 32'(act_vec()), 32'd0);
    end
    model_reset();
    cyc = 0;
    lock_cyc = -1;
    slip_q.delete();
    ext_reset = 1'b1;
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    while (tok_code(w) >= 0) w = 10'($urandom_range(0, 1023));
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{10'h2AB, 1'b0, 2'd3, 8'h00};
    vecs[1]  = '{10'h100, 1'b1, 2'd3, 8'h00};
    vecs[2]  = '{10'h2FF, 1'b1, 2'd3, 8'hFE};
    vecs[3]  = '{10'h0AB, 1'b0, 2'd1, 8'h00};
    vecs[4]  = '{10'h000, 1'b1, 2'd1, 8'hFE};
    vecs[5]  = '{10'h154, 1'b0, 2'd2, 8'h00};
    vecs[6]  = '{10'h1FF, 1'b1, 2'd2, 8'h01};
    vecs[7]  = '{10'h354, 1'b0, 2'd0, 8'h00};
    vecs[8]  = '{10'h3FF, 1'b1, 2'd0, 8'h00};
    vecs[9]  = '{10'h155, 1'b1, 2'd0, 8'hFF};
    vecs[10] = '{10'h0AA, 1'b1, 2'd0, 8'h00};
    vecs[11] = '{10'h2AA, 1'b1, 2'd0, 8'h01};
    build_tables();
    cyc = 0;
    lock_cyc = -1;

    @(negedge clk);
    do_reset();

    // Aligned blanking: lock two cycles after the 16th token.
    for (int i = 0; i < LOCK_N; i++) step(10'h354);
    check("lock_early", 32'(locked), 32'd0);
    step(10'h354);
    check("lock_rise", 32'({locked, vld}), 32'b10);
    step(10'h354);
    check("first_vld", 32'({vld, de, ctrl}), 32'b1000);

    // Decode vectors, each checked one step after it is applied.
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].din);
      if (i > 0) check("vec", 32'({vld, de, ctrl, dout}), 32'({1'b1, vecs[i-1].de, vecs[i-1].ctrl, vecs[i-1].dout}));
    end
    step(10'h354);
    check("vec", 32'({vld, de, ctrl, dout}), 32'({1'b1, vecs[11].de, vecs[11].ctrl, vecs[11].dout}));
    step(10'h354);

    // Loss of lock after LOSS_N consecutive data words, then relock.
    for (int i = 0; i < LOSS_N - 1; i++) step(rand_data());
    step(rand_data());
    check("loss_hold", 32'({locked, vld}), 32'b11);
    step(10'h354);
    check("loss_drop", 32'({locked, vld, de}), 32'b000);
    for (int i = 0; i < LOCK_N - 1; i++) step(10'h354);
    check("relock_early", 32'(locked), 32'd0);
    step(10'h354);
    check("relock", 32'(locked), 32'd1);
    step(10'h354);

`ifdef TMDS_TERC4_EN
    step(10'b1010011100);
    step(10'h354);
    check("terc4_hit", 32'({terc4_vld, terc4}), 32'h10);
    step(10'h354);
    check("terc4_clear", 32'(terc4_vld), 32'd0);
`endif

    // Reset while locked, then lock again from SEARCH.
    do_reset();
    for (int i = 0; i < LOCK_N + 1; i++) step(10'h0AB);
    check("relock_after_reset", 32'(locked), 32'd1);

    // Misaligned by 3 bits: 3 slips spaced SLIP_N+1+SETTLE_N, then lock.
    misalign = 1'b1;
    off = 3;
    do_reset();
    for (int i = 0; i < 400 && lock_cyc < 0; i++) step(10'h354);
    check("slip_count", 32'(slip_q.size()), 32'd3);
    if (slip_q.size() > 0) check("first_slip", 32'(slip_q[0]), 32'(SLIP_N));
    for (int i = 1; i < slip_q.size(); i++)
      check("slip_gap", 32'(slip_q[i] - slip_q[i-1]), 32'(SLIP_N + 1 + SETTLE_N));
    check("misalign_lock", 32'(lock_cyc), 32'(3 * SLIP_N + 2 * (1 + SETTLE_N) + 1 + SETTLE_N + LOCK_N));

    // Reset during the slip pulse aborts it at once.
    off = 3;
    do_reset();
    for (int i = 0; i < 60 && slip_q.size() == 0; i++) step(10'h354);
    check("slip_seen", 32'(slip_q.size()), 32'd1);
    do_reset();
    misalign = 1'b0;

    // Randomized bursts of tokens and arbitrary words against the model.
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 1) == 1) begin
        int n;
        logic [9:0] tk;
        n = $urandom_range(1, 24);
        for (int i = 0; i < n; i++) begin
          case ($urandom_range(0, 3))
            0: tk = 10'h354;
            1: tk = 10'h0AB;
            2: tk = 10'h154;
            default: tk = 10'h2AB;
          endcase
          step(tk);
        end
      end else begin
        int n;
        n = $urandom_range(1, 80);
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 3) == 0) step(terc_tab[$urandom_range(0, 15)]);
          else step(10'($urandom_range(0, 1023)));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
